// File: rtl/decode_pipe_reg.sv
// rtl/decode_pipe_reg.sv - IF->ID pipeline register with valid/ready handshake and 2-entry skid buffer
// Optional perf counters enabled by DECODE_PERF_EN.
module decode_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int SIDEBAND_W = 97,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_instr,
  input  logic [SIDEBAND_W-1:0] in_side,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_instr,
  output logic [SIDEBAND_W-1:0] out_side,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic                  in_ready_q;
  logic [XLEN-1:0]       main_instr;
  logic [XLEN-1:0]       skid_instr;
  logic [SIDEBAND_W-1:0] main_side;
  logic [SIDEBAND_W-1:0] skid_side;
  logic                  accept;
  logic                  fire;
  logic                  load_main_in;
  logic                  load_main_skid;
  logic                  load_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nx     = FULL;
          end
        end
        FULL: begin
          if (accept && fire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nx  = SKID;
          end else if (fire) begin
            state_nx = EMPTY;
          end
        end
        SKID: begin
          if (fire) begin
            load_main_skid = 1'b1;
            state_nx       = FULL;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // in_ready is registered from next state so fetch never sees a path from out_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != SKID);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_instr <= '0;
      main_side  <= '0;
      skid_instr <= '0;
      skid_side  <= '0;
    end else if (flush) begin
      main_instr <= '0;
      main_side  <= '0;
      skid_instr <= '0;
      skid_side  <= '0;
    end else begin
      if (load_main_in) begin
        main_instr <= in_instr;
        main_side  <= in_side;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_side  <= skid_side;
      end
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_side  <= in_side;
      end
    end
  end

  assign out_instr = main_instr;
  assign out_side  = main_side;
  assign op        = main_instr[6:0];
  assign rd        = main_instr[11:7];
  assign funct3    = main_instr[14:12];
  assign rs1       = main_instr[19:15];
  assign rs2       = main_instr[24:20];
  assign funct7    = main_instr[31:25];

`ifdef DECODE_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {PERF_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      // A flush only counts when it actually discards something.
      if (flush && out_valid && (flush_cnt != {PERF_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign perf_stall = stall_cnt;
  assign perf_flush = flush_cnt;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_decode_pipe_reg.sv
// tb/tb_decode_pipe_reg.sv - self-checking bench for decode_pipe_reg
module tb_decode_pipe_reg;
  localparam int XW = 32;
  localparam int SW = 97;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_instr = '0;
  logic [SW-1:0] in_side = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [XW-1:0] out_instr;
  logic [SW-1:0] out_side;
  logic [4:0]    rd, rs1, rs2;
  logic [6:0]    op, funct7;
  logic [2:0]    funct3;
  logic [PW-1:0] perf_stall, perf_flush;

  decode_pipe_reg dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_side(in_side),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_side(out_side),
    .rd(rd), .rs1(rs1), .rs2(rs2), .op(op), .funct3(funct3), .funct7(funct7),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered list of held entries, at most two, plus event counts.
  logic [XW-1:0] q_instr[$];
  logic [SW-1:0] q_side[$];
  logic          m_ready = 1'b1;
  int            m_stall = 0;
  int            m_flush = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_instr.delete();
      q_side.delete();
      m_ready = 1'b1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (q_instr.size() > 0 && !out_ready) m_stall++;
      if (flush) begin
        if (q_instr.size() > 0) m_flush++;
        q_instr.delete();
        q_side.delete();
        m_ready = 1'b1;
      end else begin
        logic acc;
        acc = in_valid && m_ready;
        if (q_instr.size() > 0 && out_ready) begin
          void'(q_instr.pop_front());
          void'(q_side.pop_front());
        end
        if (acc) begin
          q_instr.push_back(in_instr);
          q_side.push_back(in_side);
        end
        m_ready = (q_instr.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    chk("sb_out_valid", 128'(out_valid), 128'(q_instr.size() > 0));
    chk("sb_in_ready", 128'(in_ready), 128'(m_ready));
    if (q_instr.size() > 0) begin
      logic [31:0] e;
      e = q_instr[0];
      chk("sb_out_instr", 128'(out_instr), 128'(e));
      chk("sb_out_side", 128'(out_side), 128'(q_side[0]));
      chk("sb_fields", {rd, rs1, rs2, op, funct3, funct7},
          {e[11:7], e[19:15], e[24:20], e[6:0], e[14:12], e[31:25]});
    end
`ifdef DECODE_PERF_EN
    chk("sb_perf_stall", 128'(perf_stall), 128'(m_stall));
    chk("sb_perf_flush", 128'(perf_flush), 128'(m_flush));
`else
    chk("sb_perf_zero", 128'({perf_stall, perf_flush}), 128'(0));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] side_of(input logic [31:0] i);
    logic [127:0] r;
    r = {i, ~i, i ^ 32'h5A5A_5A5A, i + 32'd4};
    return r[SW-1:0];
  endfunction

  task automatic put(input logic v, input logic [31:0] i);
    in_valid = v;
    in_instr = i;
    in_side  = side_of(i);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_instr", 128'(out_instr), 128'(0));
    chk("rst_fields", {rd, rs1, rs2, op, funct3, funct7}, 128'(0));
    chk("rst_perf", 128'({perf_stall, perf_flush}), 128'(0));

    // Stream, zero bubble
    out_ready = 1'b1;
    put(1'b1, 32'h00500093);
    cyc();
    chk("s1_instr0", 128'(out_instr), 128'h00500093);
    put(1'b1, 32'h00A00113);
    cyc();
    chk("s1_instr1", 128'(out_instr), 128'h00A00113);
    put(1'b1, 32'h002081B3);
    cyc();
    chk("s1_instr2", 128'(out_instr), 128'h002081B3);
    chk("s1_valid", 128'(out_valid), 128'(1));
    chk("s1_fields", {rd, rs1, rs2, op, funct3, funct7},
        {5'd3, 5'd1, 5'd2, 7'h33, 3'd0, 7'd0});
    put(1'b0, 32'h0);
    cyc();
    chk("s1_drain", 128'(out_valid), 128'(0));

    // Backpressure into skid
    out_ready = 1'b0;
    put(1'b1, 32'h11111111);
    cyc();
    put(1'b1, 32'h22222222);
    cyc();
    chk("s2_in_ready_skid", 128'(in_ready), 128'(0));
    chk("s2_hold_first", 128'(out_instr), 128'h11111111);
    put(1'b1, 32'h33333333);
    out_ready = 1'b1;
    #1;
    chk("s2_ready_not_comb", 128'(in_ready), 128'(0));
    cyc();
    chk("s2_second", 128'(out_instr), 128'h22222222);
    put(1'b0, 32'h0);
    cyc();
    chk("s2_empty", 128'(out_valid), 128'(0));

    // Flush while in SKID with a live input
    out_ready = 1'b0;
    put(1'b1, 32'h44444444);
    cyc();
    put(1'b1, 32'h55555555);
    cyc();
    put(1'b1, 32'h66666666);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    put(1'b0, 32'h0);
    chk("s3_valid", 128'(out_valid), 128'(0));
    chk("s3_ready", 128'(in_ready), 128'(1));
    chk("s3_instr_zero", 128'(out_instr), 128'(0));
    cyc();
    chk("s3_dropped", 128'(out_valid), 128'(0));

    // Asynchronous reset while FULL
    put(1'b1, 32'h77777777);
    cyc();
    put(1'b0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s4_async_valid", 128'(out_valid), 128'(0));
    chk("s4_async_ready", 128'(in_ready), 128'(1));
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    put(1'b1, 32'h88888888);
    cyc();
    chk("s4_post_valid", 128'(out_valid), 128'(1));
    chk("s4_post_instr", 128'(out_instr), 128'h88888888);
    put(1'b0, 32'h0);
    cyc();

    // Perf counters from a clean reset
    do_reset();
    put(1'b1, 32'h99999999);
    cyc();
    put(1'b0, 32'h0);
    repeat (5) cyc();
`ifdef DECODE_PERF_EN
    chk("s6_stall5", 128'(perf_stall), 128'(5));
`else
    chk("s6_stall_off", 128'(perf_stall), 128'(0));
`endif
    flush = 1'b1;
    cyc();
    flush = 1'b0;
`ifdef DECODE_PERF_EN
    chk("s6_flush1", 128'(perf_flush), 128'(1));
`else
    chk("s6_flush_off", 128'(perf_flush), 128'(0));
`endif

    // Random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      put($urandom_range(0, 3) != 0, $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      cyc();
    end
    flush = 1'b0;
    put(1'b0, 32'h0);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("s5_drained", 128'(out_valid), 128'(0));

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
